// File: rtl/snitch_cluster_cfg_regfile.sv
// Runtime cluster configuration register file.
// Holds shadow copies of the boot address, the per-core enables and the cached
// region rules. Software writes the shadows over a single-cycle register bus,
// then issues COMMIT. The commit sequence drains the cores, flushes the
// instruction cache, and copies shadow to active in a single cycle.
// Optional build macro: CFG_REGION_LOCK_EN adds a sticky per-rule LOCK register
// at 0x14. The lock blocks BASE/MASK writes and REGION_EN bit changes for
// locked rules.

// One region rule: shadow and active base/mask pair.
module snitch_cluster_cfg_region_rule #(
   parameter int unsigned          AddrWidth = 32,
   parameter logic [AddrWidth-1:0] BaseRst   = '0,
   parameter logic [AddrWidth-1:0] MaskRst   = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 base_we,
   input  logic                 mask_we,
   input  logic [AddrWidth-1:0] wdata,
   input  logic                 commit,
   output logic [AddrWidth-1:0] shadow_base,
   output logic [AddrWidth-1:0] shadow_mask,
   output logic [AddrWidth-1:0] active_base,
   output logic [AddrWidth-1:0] active_mask
);

   // Shadow copy: written by the register bus.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_base <= BaseRst;
         shadow_mask <= MaskRst;
      end else begin
         if (base_we) shadow_base <= wdata;
         if (mask_we) shadow_mask <= wdata;
      end
   end

   // Active copy: follows the shadow only in the COMMIT cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_base <= BaseRst;
         active_mask <= MaskRst;
      end else if (commit) begin
         active_base <= shadow_base;
         active_mask <= shadow_mask;
      end
   end

endmodule

module snitch_cluster_cfg_regfile #(
   parameter int unsigned          NrCores        = 8,
   parameter int unsigned          NrRegionRules  = 4,
   parameter int unsigned          AddrWidth      = 32,
   parameter logic [AddrWidth-1:0] BootAddrRst    = 32'h1E00_0000,
   parameter logic [AddrWidth-1:0] Region0BaseRst = 32'h1E00_0000,
   parameter logic [AddrWidth-1:0] Region0MaskRst = 32'h0080_0000,
   parameter int unsigned          DrainTimeout   = 1024
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 reg_req_valid_i,
   output logic                                 reg_req_ready_o,
   input  logic                                 reg_req_write_i,
   input  logic [7:0]                           reg_req_addr_i,
   input  logic [31:0]                          reg_req_wdata_i,
   output logic                                 reg_rsp_valid_o,
   output logic [31:0]                          reg_rsp_rdata_o,
   output logic                                 reg_rsp_error_o,
   input  logic [NrCores-1:0]                   core_idle_i,
   output logic                                 flush_req_o,
   input  logic                                 flush_ack_i,
   output logic [AddrWidth-1:0]                 boot_addr_o,
   output logic [NrCores-1:0]                   core_en_o,
   output logic [NrRegionRules-1:0]             region_en_o,
   output logic [NrRegionRules*AddrWidth-1:0]   region_base_o,
   output logic [NrRegionRules*AddrWidth-1:0]   region_mask_o,
   output logic                                 commit_busy_o,
   output logic [15:0]                          cfg_epoch_o
);

   localparam int unsigned CntW = $clog2(DrainTimeout);

   typedef struct packed {
      logic        write;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } reg_req_t;

   typedef struct packed {
      logic        error;
      logic [31:0] rdata;
   } reg_rsp_t;

   typedef enum logic [1:0] {StIdle, StDrain, StFlush, StCommit} state_e;

   reg_req_t req;
   reg_rsp_t rsp_d, rsp_q;
   logic     rsp_vld_q;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              busy, do_commit, flush_q;
   logic [15:0]       epoch_q;

   logic [AddrWidth-1:0]     boot_sq, boot_q;
   logic [NrCores-1:0]       core_en_sq, core_en_q;
   logic [NrRegionRules-1:0] region_en_sq, region_en_q;
   logic [NrRegionRules-1:0] lock_q;

   logic [NrRegionRules-1:0][AddrWidth-1:0] base_sq, mask_sq, base_q, mask_q;

   logic                     boot_we, core_en_we, region_en_we;
   logic [NrRegionRules-1:0] base_we, mask_we;
   logic                     commit_cmd, abort_cmd, rule_hit;
   logic [4:0]               rule_idx;
`ifdef CFG_REGION_LOCK_EN
   logic                     lock_we;
`endif

   assign req             = {reg_req_write_i, reg_req_addr_i, reg_req_wdata_i};
   assign busy            = (state_q != StIdle);
   assign reg_req_ready_o = 1'b1;
   assign reg_rsp_valid_o = rsp_vld_q;
   assign reg_rsp_rdata_o = rsp_q.rdata;
   assign reg_rsp_error_o = rsp_q.error;
   assign flush_req_o     = flush_q;
   assign commit_busy_o   = busy;
   assign cfg_epoch_o     = epoch_q;
   assign boot_addr_o     = boot_q;
   assign core_en_o       = core_en_q;
   assign region_en_o     = region_en_q;

   // Address decode: produce the response word and single-cycle write strobes.
   always_comb begin
      rsp_d        = '0;
      boot_we      = 1'b0;
      core_en_we   = 1'b0;
      region_en_we = 1'b0;
      base_we      = '0;
      mask_we      = '0;
      commit_cmd   = 1'b0;
      abort_cmd    = 1'b0;
      rule_hit     = 1'b0;
`ifdef CFG_REGION_LOCK_EN
      lock_we      = 1'b0;
`endif
      rule_idx     = req.addr[7:3] - 5'd4;
      if (reg_req_valid_i) begin
         if (req.addr[1:0] != 2'b00) begin
            rsp_d.error = 1'b1;
         end else if (req.addr >= 8'h20) begin
            // Rule window: 0x20 + 8*i is BASE, +4 is MASK.
            for (int unsigned i = 0; i < NrRegionRules; i++) begin
               if (rule_idx == 5'(i)) begin
                  rule_hit = 1'b1;
                  if (!req.write)
                     rsp_d.rdata = req.addr[2] ? 32'(mask_sq[i]) : 32'(base_sq[i]);
                  else if (busy || lock_q[i])
                     rsp_d.error = 1'b1;
                  else if (req.addr[2])
                     mask_we[i] = 1'b1;
                  else
                     base_we[i] = 1'b1;
               end
            end
            if (!rule_hit) rsp_d.error = 1'b1;
         end else begin
            case (req.addr)
               8'h00: if (req.write) begin
                  // ABORT has priority. COMMIT plus ABORT in IDLE is a silent no-op.
                  abort_cmd = req.wdata[1];
                  if (req.wdata[0] && !req.wdata[1]) begin
                     if (busy) rsp_d.error = 1'b1;
                     else      commit_cmd  = 1'b1;
                  end
               end
               8'h04: begin
                  if (req.write) rsp_d.error = 1'b1;
                  else           rsp_d.rdata = {epoch_q, 14'b0, timeout_q, busy};
               end
               8'h08: begin
                  if (!req.write) rsp_d.rdata = 32'(boot_sq);
                  else if (busy)  rsp_d.error = 1'b1;
                  else            boot_we     = 1'b1;
               end
               8'h0C: begin
                  if (!req.write) rsp_d.rdata = 32'(core_en_sq);
                  else if (busy)  rsp_d.error = 1'b1;
                  else            core_en_we  = 1'b1;
               end
               8'h10: begin
                  if (!req.write)
                     rsp_d.rdata = 32'(region_en_sq);
                  else if (busy ||
                           (|((req.wdata[NrRegionRules-1:0] ^ region_en_sq) & lock_q)))
                     rsp_d.error = 1'b1;
                  else
                     region_en_we = 1'b1;
               end
`ifdef CFG_REGION_LOCK_EN
               8'h14: begin
                  if (req.write) lock_we     = 1'b1;
                  else           rsp_d.rdata = 32'(lock_q);
               end
`endif
               default: rsp_d.error = 1'b1;
            endcase
         end
      end
   end

   // Response register: exactly one response, one cycle after each request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_vld_q <= 1'b0;
         rsp_q     <= '0;
      end else begin
         rsp_vld_q <= reg_req_valid_i;
         rsp_q     <= rsp_d;
      end
   end

`ifdef CFG_REGION_LOCK_EN
   // Sticky lock bits: write-1-to-set, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      lock_q <= '0;
      else if (lock_we) lock_q <= lock_q | req.wdata[NrRegionRules-1:0];
   end
`else
   assign lock_q = '0;
`endif

   // Commit sequencer: next state, drain counter and timeout sticky.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      do_commit = 1'b0;
      case (state_q)
         StIdle: if (commit_cmd) begin
            state_d   = StDrain;
            cnt_d     = '0;
            timeout_d = 1'b0;
         end
         StDrain: begin
            // Disabled cores count as idle. The active enables decide this.
            if (abort_cmd)
               state_d = StIdle;
            else if (&(core_idle_i | ~core_en_q))
               state_d = StFlush;
            else if (cnt_q == CntW'(DrainTimeout - 1)) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         StFlush: if (flush_ack_i) state_d = StCommit;
         StCommit: begin
            do_commit = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state, plus the registered flush request that tracks FLUSH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         flush_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         flush_q   <= (state_d == StFlush);
      end
   end

   // Shadow boot address and enables, written by the register bus.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         boot_sq      <= BootAddrRst;
         core_en_sq   <= '1;
         region_en_sq <= NrRegionRules'(1);
      end else begin
         if (boot_we)      boot_sq      <= AddrWidth'(req.wdata);
         if (core_en_we)   core_en_sq   <= req.wdata[NrCores-1:0];
         if (region_en_we) region_en_sq <= req.wdata[NrRegionRules-1:0];
      end
   end

   // Active boot address, enables and epoch: updated only in the COMMIT cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         boot_q      <= BootAddrRst;
         core_en_q   <= '1;
         region_en_q <= NrRegionRules'(1);
         epoch_q     <= '0;
      end else if (do_commit) begin
         boot_q      <= boot_sq;
         core_en_q   <= core_en_sq;
         region_en_q <= region_en_sq;
         epoch_q     <= epoch_q + 16'd1;
      end
   end

   for (genvar i = 0; i < NrRegionRules; i++) begin : gen_rule
      snitch_cluster_cfg_region_rule #(
         .AddrWidth (AddrWidth),
         .BaseRst   ((i == 0) ? Region0BaseRst : {AddrWidth{1'b0}}),
         .MaskRst   ((i == 0) ? Region0MaskRst : {AddrWidth{1'b0}})
      ) u_rule (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .base_we     (base_we[i]),
         .mask_we     (mask_we[i]),
         .wdata       (AddrWidth'(req.wdata)),
         .commit      (do_commit),
         .shadow_base (base_sq[i]),
         .shadow_mask (mask_sq[i]),
         .active_base (base_q[i]),
         .active_mask (mask_q[i])
      );
      assign region_base_o[i*AddrWidth +: AddrWidth] = base_q[i];
      assign region_mask_o[i*AddrWidth +: AddrWidth] = mask_q[i];
   end

endmodule

// File: tb/tb_snitch_cluster_cfg_regfile.sv
// Scoreboard bench for snitch_cluster_cfg_regfile. Requests push their
// expected response into a queue, and a negedge monitor pops and compares each
// response. Direct output checks run from the stimulus process.
// Build with CFG_REGION_LOCK_EN to exercise the LOCK register.
module tb_snitch_cluster_cfg_regfile;
   localparam int unsigned NC = 8;
   localparam int unsigned NR = 4;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid, req_ready, req_write;
   logic [7:0]    req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_error;
   logic [31:0]   rsp_rdata;
   logic [NC-1:0] core_idle;
   logic          flush_req, flush_ack;
   logic [AW-1:0] boot_addr;
   logic [NC-1:0] core_en;
   logic [NR-1:0] region_en;
   logic [NR*AW-1:0] region_base, region_mask;
   logic          busy;
   logic [15:0]   epoch;

   int n_chk = 0;
   int n_fail = 0;
   logic [32:0] exp_q[$];
   string       name_q[$];
   logic [32:0] mon_e;
   string       mon_n;

   always #5 clk = ~clk;

   snitch_cluster_cfg_regfile #(
      .NrCores(NC), .NrRegionRules(NR), .AddrWidth(AW), .DrainTimeout(1024)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .reg_req_valid_i(req_valid), .reg_req_ready_o(req_ready),
      .reg_req_write_i(req_write), .reg_req_addr_i(req_addr),
      .reg_req_wdata_i(req_wdata), .reg_rsp_valid_o(rsp_valid),
      .reg_rsp_rdata_o(rsp_rdata), .reg_rsp_error_o(rsp_error),
      .core_idle_i(core_idle), .flush_req_o(flush_req), .flush_ack_i(flush_ack),
      .boot_addr_o(boot_addr), .core_en_o(core_en), .region_en_o(region_en),
      .region_base_o(region_base), .region_mask_o(region_mask),
      .commit_busy_o(busy), .cfg_epoch_o(epoch)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request and queue its expected response.
   task automatic do_req(input string name, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
      exp_q.push_back({eerr, erd});
      name_q.push_back(name);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Wait for a flush request, ack it after 'delay' cycles, then wait for idle.
   task automatic run_flush(input int delay);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (flush_req) break;
      end
      chk("flush_req raised", 128'(flush_req), 128'(1));
      repeat (delay) @(negedge clk);
      flush_ack = 1'b1;
      @(posedge clk); #1;
      flush_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("busy dropped after flush", 128'(busy), 128'(0));
      chk("flush_req dropped", 128'(flush_req), 128'(0));
   endtask

   // Monitor: every response must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected response: rdata %0h error %0b, none queued", rsp_rdata, rsp_error);
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            chk({mon_n, " error"}, 128'(rsp_error), 128'(mon_e[32]));
            chk({mon_n, " rdata"}, 128'(rsp_rdata), 128'(mon_e[31:0]));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      logic flush_seen;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      core_idle = '1; flush_ack = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst boot", 128'(boot_addr), 128'(32'h1E00_0000));
      chk("rst core_en", 128'(core_en), 128'(8'hFF));
      chk("rst region_en", 128'(region_en), 128'(4'h1));
      chk("rst base", 128'(region_base), {96'h0, 32'h1E00_0000});
      chk("rst mask", 128'(region_mask), {96'h0, 32'h0080_0000});
      chk("rst epoch", 128'(epoch), 128'(0));
      chk("rst rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst flush_req", 128'(flush_req), 128'(0));
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready", 128'(req_ready), 128'(1));
      sync();

      // Read map and error decoding.
      do_req("rd boot",       0, 8'h08, 0, 32'h1E00_0000, 0);
      do_req("rd mask0",      0, 8'h24, 0, 32'h0080_0000, 0);
      do_req("rd base0",      0, 8'h20, 0, 32'h1E00_0000, 0);
      do_req("rd rule4 base", 0, 8'h40, 0, 0, 1);
      do_req("rd rule4 mask", 0, 8'h44, 0, 0, 1);
      do_req("rd core_en",    0, 8'h0C, 0, 32'hFF, 0);
      do_req("rd region_en",  0, 8'h10, 0, 32'h1, 0);
      do_req("rd ctrl",       0, 8'h00, 0, 0, 0);
      do_req("rd status",     0, 8'h04, 0, 0, 0);
      do_req("wr status",     1, 8'h04, 32'hFFFF, 0, 1);
      do_req("rd unmapped",   0, 8'h18, 0, 0, 1);
      do_req("rd misaligned", 0, 8'h0A, 0, 0, 1);
`ifndef CFG_REGION_LOCK_EN
      do_req("rd lock unmapped", 0, 8'h14, 0, 0, 1);
      do_req("wr lock unmapped", 1, 8'h14, 2, 0, 1);
`endif

      // Shadow writes, including width truncation.
      do_req("wr boot",      1, 8'h08, 32'h8000_0000, 0, 0);
      do_req("wr core_en",   1, 8'h0C, 32'hFFFF_FFFF, 0, 0);
      do_req("wr region_en", 1, 8'h10, 32'hFFFF_FFF3, 0, 0);
      do_req("wr base1",     1, 8'h28, 32'h8000_0000, 0, 0);
      do_req("wr mask1",     1, 8'h2C, 32'h000F_0000, 0, 0);
      do_req("rd core_en trunc",   0, 8'h0C, 0, 32'hFF, 0);
      do_req("rd region_en trunc", 0, 8'h10, 0, 32'h3, 0);
      do_req("rd base1",           0, 8'h28, 0, 32'h8000_0000, 0);
      chk("active boot before commit", 128'(boot_addr), 128'(32'h1E00_0000));
      chk("active region_en before commit", 128'(region_en), 128'(4'h1));

      // Minimum-latency commit: ack is high for the first FLUSH cycle.
      do_req("commit1", 1, 8'h00, 32'h1, 0, 0);
      flush_ack = 1'b1;
      @(negedge clk);
      chk("c1 drain busy", 128'(busy), 128'(1));
      chk("c1 drain no flush", 128'(flush_req), 128'(0));
      @(negedge clk);
      chk("c1 flush_req", 128'(flush_req), 128'(1));
      @(posedge clk); #1;
      flush_ack = 1'b0;
      @(negedge clk);
      chk("c1 commit cycle boot old", 128'(boot_addr), 128'(32'h1E00_0000));
      chk("c1 commit cycle busy", 128'(busy), 128'(1));
      @(negedge clk);
      chk("c1 boot", 128'(boot_addr), 128'(32'h8000_0000));
      chk("c1 epoch", 128'(epoch), 128'(1));
      chk("c1 busy", 128'(busy), 128'(0));
      chk("c1 region_en", 128'(region_en), 128'(4'h3));
      chk("c1 base", 128'(region_base), {64'h0, 32'h8000_0000, 32'h1E00_0000});
      chk("c1 mask", 128'(region_mask), {64'h0, 32'h000F_0000, 32'h0080_0000});
      sync();
      do_req("status after c1", 0, 8'h04, 0, 32'h0001_0000, 0);

      // Drain timeout: core 3 never idles.
      core_idle[3] = 1'b0;
      do_req("wr boot shadow", 1, 8'h08, 32'h1234_5678, 0, 0);
      do_req("commit2",        1, 8'h00, 32'h1, 0, 0);
      busy_cycles = 0;
      flush_seen  = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (flush_req) flush_seen = 1'b1;
         if (!busy) break;
         busy_cycles++;
      end
      chk("timeout drain cycles", 128'(busy_cycles), 128'(1024));
      chk("timeout no flush", 128'(flush_seen), 128'(0));
      chk("timeout boot unchanged", 128'(boot_addr), 128'(32'h8000_0000));
      chk("timeout epoch unchanged", 128'(epoch), 128'(1));
      sync();
      do_req("status timeout",   0, 8'h04, 0, 32'h0001_0002, 0);
      do_req("rd boot shadow",   0, 8'h08, 0, 32'h1234_5678, 0);

      // Busy-time errors, then ABORT.
      do_req("commit3",         1, 8'h00, 32'h1, 0, 0);
      do_req("wr base1 busy",   1, 8'h28, 32'hDEAD_0000, 0, 1);
      do_req("rd base1 busy",   0, 8'h28, 0, 32'h8000_0000, 0);
      do_req("commit busy",     1, 8'h00, 32'h1, 0, 1);
      do_req("status drain",    0, 8'h04, 0, 32'h0001_0001, 0);
      do_req("wr boot busy",    1, 8'h08, 32'h0BAD_0000, 0, 1);
      do_req("abort+commit",    1, 8'h00, 32'h3, 0, 0);
      do_req("status aborted",  0, 8'h04, 0, 32'h0001_0000, 0);
      @(negedge clk);
      chk("abort busy", 128'(busy), 128'(0));
      chk("abort epoch", 128'(epoch), 128'(1));
      chk("abort boot", 128'(boot_addr), 128'(32'h8000_0000));
      sync();
      do_req("abort idle",   1, 8'h00, 32'h2, 0, 0);
      do_req("commit+abort idle", 1, 8'h00, 32'h3, 0, 0);
      do_req("ctrl zero",    1, 8'h00, 32'h0, 0, 0);
      do_req("status idle",  0, 8'h04, 0, 32'h0001_0000, 0);
      do_req("rd boot kept", 0, 8'h08, 0, 32'h1234_5678, 0);

      // Commit with the ack one cycle late; core 3 is disabled afterwards.
      core_idle = '1;
      do_req("wr core_en f7",  1, 8'h0C, 32'hF7, 0, 0);
      do_req("wr region_en 1", 1, 8'h10, 32'h1, 0, 0);
      do_req("commit4",        1, 8'h00, 32'h1, 0, 0);
      run_flush(1);
      chk("c4 core_en", 128'(core_en), 128'(8'hF7));
      chk("c4 region_en", 128'(region_en), 128'(4'h1));
      chk("c4 boot", 128'(boot_addr), 128'(32'h1234_5678));
      chk("c4 epoch", 128'(epoch), 128'(2));
      chk("c4 base", 128'(region_base), {64'h0, 32'h8000_0000, 32'h1E00_0000});

      // A disabled core that is not idle must not stall the drain.
      core_idle[3] = 1'b0;
      sync();
      do_req("commit5", 1, 8'h00, 32'h1, 0, 0);
      run_flush(0);
      chk("c5 epoch", 128'(epoch), 128'(3));
      sync();

`ifdef CFG_REGION_LOCK_EN
      do_req("wr lock",            1, 8'h14, 32'h2, 0, 0);
      do_req("rd lock",            0, 8'h14, 0, 32'h2, 0);
      do_req("wr mask1 locked",    1, 8'h2C, 32'h1, 0, 1);
      do_req("wr base1 locked",    1, 8'h28, 32'h1, 0, 1);
      do_req("wr mask0 unlocked",  1, 8'h24, 32'h0040_0000, 0, 0);
      do_req("rd mask0",           0, 8'h24, 0, 32'h0040_0000, 0);
      do_req("rd mask1 kept",      0, 8'h2C, 0, 32'h000F_0000, 0);
      do_req("wr region_en bit1",  1, 8'h10, 32'h3, 0, 1);
      do_req("wr region_en bit0",  1, 8'h10, 32'h0, 0, 0);
      do_req("rd region_en",       0, 8'h10, 0, 32'h0, 0);
      do_req("wr lock more",       1, 8'h14, 32'h1, 0, 0);
      do_req("rd lock sticky",     0, 8'h14, 0, 32'h3, 0);
`endif

      // Reset in the middle of FLUSH: no partial commit, everything back to reset.
      do_req("wr boot c6", 1, 8'h08, 32'hCAFE_0000, 0, 0);
      do_req("commit6",    1, 8'h00, 32'h1, 0, 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (flush_req) break;
      end
      chk("c6 flush_req", 128'(flush_req), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("mid rst boot", 128'(boot_addr), 128'(32'h1E00_0000));
      chk("mid rst epoch", 128'(epoch), 128'(0));
      chk("mid rst busy", 128'(busy), 128'(0));
      chk("mid rst flush_req", 128'(flush_req), 128'(0));
      chk("mid rst core_en", 128'(core_en), 128'(8'hFF));
      chk("mid rst base", 128'(region_base), {96'h0, 32'h1E00_0000});
      chk("mid rst mask", 128'(region_mask), {96'h0, 32'h0080_0000});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sync();
      do_req("rd boot after rst",   0, 8'h08, 0, 32'h1E00_0000, 0);
      do_req("rd base1 after rst",  0, 8'h28, 0, 32'h0, 0);
      do_req("rd mask0 after rst",  0, 8'h24, 0, 32'h0080_0000, 0);
      do_req("status after rst",    0, 8'h04, 0, 32'h0, 0);
`ifdef CFG_REGION_LOCK_EN
      do_req("rd lock after rst",   0, 8'h14, 0, 32'h0, 0);
`endif
      repeat (3) @(negedge clk);
      chk("scoreboard drained", 128'(exp_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/snitch_cluster_cfg_regfile.md
Name: snitch_cluster_cfg_regfile

Overview:
Runtime-programmable successor to the static cluster configuration: holds boot address, per-core enable and N cached/PMA region rules in shadow registers written over a simple register bus. A commit sequence drains the cores, flushes the instruction cache and then atomically copies shadow to active. Sits beside the cluster; active outputs drive core boot/enable and PMA region inputs.

Parameters:
NrCores, 8, number of cores (1..16)
NrRegionRules, 4, programmable cached regions (1..8)
AddrWidth, 32, address width of boot/region values
BootAddrRst, 32'h1E00_0000, reset boot address (shadow and active)
Region0BaseRst, 32'h1E00_0000, reset base of region 0
Region0MaskRst, 32'h0080_0000, reset mask of region 0
DrainTimeout, 1024, max DRAIN cycles before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
reg_req_valid_i  in  1  request valid
reg_req_ready_o  out  1  request ready, constant 1 out of reset
reg_req_write_i  in  1  1=write, 0=read
reg_req_addr_i  in  8  byte address, word aligned
reg_req_wdata_i  in  32  write data
reg_rsp_valid_o  out  1  response valid, one cycle after request
reg_rsp_rdata_o  out  32  read data (0 on writes/errors)
reg_rsp_error_o  out  1  access error
core_idle_i  in  NrCores  per-core idle
flush_req_o  out  1  icache flush request
flush_ack_i  in  1  flush done pulse
boot_addr_o  out  AddrWidth  active boot address
core_en_o  out  NrCores  active core enables
region_en_o  out  NrRegionRules  active region enables
region_base_o  out  NrRegionRules*AddrWidth  active bases, packed, rule i at [i*AddrWidth +: AddrWidth]
region_mask_o  out  NrRegionRules*AddrWidth  active masks, same packing
commit_busy_o  out  1  FSM not IDLE
cfg_epoch_o  out  16  successful commit count

Behaviour:
- Reset: shadow=active; boot=BootAddrRst, core_en all 1, region_en=1 (rule 0), base0/mask0 = Region0*Rst, others 0; epoch 0; flush_req_o 0; rsp_valid 0; FSM IDLE; timeout sticky 0.
- Map: 0x00 CTRL (W: bit0 COMMIT, bit1 ABORT; reads 0); 0x04 STATUS (RO: bit0 busy, bit1 timeout, [31:16] epoch); 0x08 BOOT; 0x0C CORE_EN; 0x10 REGION_EN; 0x20+8i BASE[i]; 0x24+8i MASK[i]. Shadow registers read back shadow value.
- Error (rdata 0, no state change): unmapped address, rule index >= NrRegionRules, write to STATUS, shadow write while busy, COMMIT while busy. Reads always allowed.
- Each accepted request gives exactly one response the following cycle; back-to-back requests every cycle supported.
- FSM: IDLE -COMMIT-> DRAIN (clears timeout sticky, counter 0). DRAIN: when (core_idle_i | ~active core_en) all 1 -> FLUSH; ABORT -> IDLE no commit; counter reaching DrainTimeout-1 -> IDLE, timeout=1. FLUSH: flush_req_o=1 (registered) until flush_ack_i sampled, then COMMIT. ABORT in FLUSH ignored. COMMIT: one cycle, active<=shadow, epoch+1 (wraps 0xFFFF->0), -> IDLE. Active outputs change the cycle after COMMIT.
- Minimum commit latency: request cycle +1 DRAIN, +1 FLUSH (ack same cycle), +1 COMMIT -> outputs updated 4 cycles after request.
- COMMIT and ABORT both set: ABORT wins, treated as no-op in IDLE (no error).
- Reset mid-sequence: everything to reset values; no partial commit.
- Width rules: writes to CORE_EN/REGION_EN use low NrCores/NrRegionRules bits, upper ignored; reads zero-extend.

Optional Feature:
CFG_REGION_LOCK_EN: adds 0x14 LOCK (NrRegionRules bits, write-1-to-set, clears only on reset). Locked rule: BASE/MASK writes and its REGION_EN bit changes return error (whole write rejected). Without macro: 0x14 is unmapped (error), no lock state.

Test Plan:
- Reset -> boot_addr_o=0x1E000000, core_en_o=0xFF, region_en_o=0x1, mask0=0x00800000, epoch 0, rsp_valid 0.
- Write BOOT=0x80000000, COMMIT, all idle, ack next cycle -> boot_addr_o=0x80000000 after commit, epoch=1, busy dropped.
- Core 3 held busy 2000 cycles after COMMIT -> timeout at cycle 1024, STATUS=0x0002 busy 0, outputs unchanged, no flush_req_o.
- Write BASE[1] while in DRAIN -> rsp_error 1, readback shows old value; ABORT -> IDLE, epoch unchanged.
- Read 0x20+8*4 with NrRegionRules=4 -> error; read 0x24 returns shadow MASK[0].
- With CFG_REGION_LOCK_EN: write LOCK=0x2, then MASK[1] -> error; MASK[0] write accepted.
